// File: rtl/rob_pkg.sv
// Shared sizing, entry layout and state encoding for the reorder buffer.
package rob_pkg;

    localparam int unsigned ROB_SIZE_LOG = 4;
    localparam int unsigned ROB_SIZE     = 1 << ROB_SIZE_LOG;

    typedef logic [ROB_SIZE_LOG-1:0] rob_tag_t;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        is_branch;
        logic        pred_jump;
        logic        jump;
        logic [31:0] alt_pc;
    } rob_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_CLEAR
    } rob_state_t;

    function automatic logic is_mispredict(input rob_entry_t e, input logic jump);
        return e.is_branch && (jump != e.pred_jump);
    endfunction

endpackage

// File: rtl/rob_entry_array.sv
// Reorder-buffer entry storage: one issue write port, one CDB write port,
// a full-entry head read port and two operand query read ports.
module rob_entry_array #(
    parameter int unsigned TAG_W = rob_pkg::ROB_SIZE_LOG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                issue_en,
    input  logic [TAG_W-1:0]    issue_idx,
    input  rob_pkg::rob_entry_t issue_entry,
    input  logic                cdb_en,
    input  logic [TAG_W-1:0]    cdb_idx,
    input  logic [31:0]         cdb_val,
    input  logic                cdb_jump,
    input  logic                retire_en,
    input  logic [TAG_W-1:0]    retire_idx,
    input  logic [TAG_W-1:0]    head_idx,
    output rob_pkg::rob_entry_t head_entry,
    input  logic [TAG_W-1:0]    query_idx_1,
    output logic                query_busy_1,
    output logic                query_ready_1,
    output logic [31:0]         query_val_1,
    input  logic [TAG_W-1:0]    query_idx_2,
    output logic                query_busy_2,
    output logic                query_ready_2,
    output logic [31:0]         query_val_2
);
    import rob_pkg::*;

    localparam int unsigned DEPTH = 1 << TAG_W;

    rob_entry_t entries [DEPTH];

    // Retire is applied last so a late duplicate CDB write cannot keep a retired entry busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].busy <= 1'b0;
            end
        end else begin
            if (issue_en) begin
                entries[issue_idx] <= issue_entry;
            end
            if (cdb_en && entries[cdb_idx].busy) begin
                entries[cdb_idx].ready <= 1'b1;
                entries[cdb_idx].val   <= cdb_val;
                entries[cdb_idx].jump  <= cdb_jump;
            end
            if (retire_en) begin
                entries[retire_idx].busy <= 1'b0;
            end
        end
    end

    assign head_entry    = entries[head_idx];
    assign query_busy_1  = entries[query_idx_1].busy;
    assign query_ready_1 = entries[query_idx_1].ready;
    assign query_val_1   = entries[query_idx_1].val;
    assign query_busy_2  = entries[query_idx_2].busy;
    assign query_ready_2 = entries[query_idx_2].ready;
    assign query_val_2   = entries[query_idx_2].val;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer for the Tomasulo core with mispredict flush.
// Optional feature macro: ROB_CDB_BYPASS_EN (same-cycle CDB commit and query forwarding).
module reorder_buffer #(
    parameter int unsigned ROB_SIZE_LOG = rob_pkg::ROB_SIZE_LOG
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_is_branch,
    input  logic                    issue_pred_jump,
    input  logic [31:0]             issue_alt_pc,
    output logic [ROB_SIZE_LOG-1:0] issue_tag,
    output logic                    rob_full,
    input  logic                    cdb_valid,
    input  logic [ROB_SIZE_LOG-1:0] cdb_tag,
    input  logic [31:0]             cdb_val,
    input  logic                    cdb_jump,
    input  logic [ROB_SIZE_LOG-1:0] query_tag_1,
    output logic                    query_ready_1,
    output logic [31:0]             query_val_1,
    input  logic [ROB_SIZE_LOG-1:0] query_tag_2,
    output logic                    query_ready_2,
    output logic [31:0]             query_val_2,
    output logic [4:0]              commit_reg,
    output logic [31:0]             commit_val,
    output logic [ROB_SIZE_LOG-1:0] commit_tag,
    output logic                    RoB_clear,
    output logic [31:0]             clear_pc
);
    import rob_pkg::*;

    typedef logic [ROB_SIZE_LOG-1:0] tag_t;
    typedef logic [ROB_SIZE_LOG:0]   cnt_t;

    localparam tag_t TAG_ONE  = tag_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = CNT_ONE << ROB_SIZE_LOG;

    tag_t        head, tail;
    cnt_t        count;
    rob_state_t  state;
    rob_entry_t  head_e, new_e;
    logic        q1_busy, q1_ready, q2_busy, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        running, do_issue, do_commit, flush;
    logic        head_ready, head_jump;
    logic [31:0] head_val;

    assign issue_tag = tail;
    assign rob_full  = (count == CNT_FULL);
    assign running   = rdy_in && (state == ST_RUN);
    assign do_issue  = running && issue_valid && !rob_full;
    assign do_commit = running && head_e.busy && head_ready;
    assign flush     = do_commit && is_mispredict(head_e, head_jump);

    always_comb begin
        new_e           = '0;
        new_e.busy      = 1'b1;
        new_e.rd        = issue_rd;
        new_e.is_branch = issue_is_branch;
        new_e.pred_jump = issue_pred_jump;
        new_e.alt_pc    = issue_alt_pc;
    end

    always_comb begin
        head_ready    = head_e.ready;
        head_val      = head_e.val;
        head_jump     = head_e.jump;
        query_ready_1 = q1_busy && q1_ready;
        query_val_1   = q1_val;
        query_ready_2 = q2_busy && q2_ready;
        query_val_2   = q2_val;
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_tag == head) && !head_e.ready) begin
            head_ready = 1'b1;
            head_val   = cdb_val;
            head_jump  = cdb_jump;
        end
        if (cdb_valid && (cdb_tag == query_tag_1) && q1_busy && !q1_ready) begin
            query_ready_1 = 1'b1;
            query_val_1   = cdb_val;
        end
        if (cdb_valid && (cdb_tag == query_tag_2) && q2_busy && !q2_ready) begin
            query_ready_2 = 1'b1;
            query_val_2   = cdb_val;
        end
`endif
    end

    rob_entry_array #(
        .TAG_W (ROB_SIZE_LOG)
    ) u_entries (
        .clk           (clk_in),
        .rst           (rst_in),
        .flush         (flush),
        .issue_en      (do_issue),
        .issue_idx     (tail),
        .issue_entry   (new_e),
        .cdb_en        (running && cdb_valid),
        .cdb_idx       (cdb_tag),
        .cdb_val       (cdb_val),
        .cdb_jump      (cdb_jump),
        .retire_en     (do_commit),
        .retire_idx    (head),
        .head_idx      (head),
        .head_entry    (head_e),
        .query_idx_1   (query_tag_1),
        .query_busy_1  (q1_busy),
        .query_ready_1 (q1_ready),
        .query_val_1   (q1_val),
        .query_idx_2   (query_tag_2),
        .query_busy_2  (q2_busy),
        .query_ready_2 (q2_ready),
        .query_val_2   (q2_val)
    );

    // The mispredicting commit empties the buffer on its own edge; the following
    // clear cycle then only drops the pulse and blocks issue, CDB and commit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            state      <= ST_RUN;
            commit_reg <= '0;
            commit_val <= '0;
            commit_tag <= '0;
            RoB_clear  <= 1'b0;
            clear_pc   <= '0;
        end else if (rdy_in) begin
            case (state)
                ST_RUN: begin
                    commit_reg <= do_commit ? head_e.rd : '0;
                    commit_val <= do_commit ? head_val : '0;
                    commit_tag <= do_commit ? head : '0;
                    if (flush) begin
                        head      <= '0;
                        tail      <= '0;
                        count     <= '0;
                        RoB_clear <= 1'b1;
                        clear_pc  <= head_e.alt_pc;
                        state     <= ST_CLEAR;
                    end else begin
                        if (do_commit) head <= head + TAG_ONE;
                        if (do_issue)  tail <= tail + TAG_ONE;
                        case ({do_issue, do_commit})
                            2'b10:   count <= count + CNT_ONE;
                            2'b01:   count <= count - CNT_ONE;
                            default: count <= count;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    commit_reg <= '0;
                    commit_val <= '0;
                    commit_tag <= '0;
                    RoB_clear  <= 1'b0;
                    clear_pc   <= '0;
                    state      <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (default build, no CDB bypass).
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_valid, issue_is_branch, issue_pred_jump;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc;
    logic [3:0]  issue_tag;
    logic        rob_full;
    logic        cdb_valid, cdb_jump;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic [3:0]  query_tag_1, query_tag_2;
    logic        query_ready_1, query_ready_2;
    logic [31:0] query_val_1, query_val_2;
    logic [4:0]  commit_reg;
    logic [31:0] commit_val;
    logic [3:0]  commit_tag;
    logic        RoB_clear;
    logic [31:0] clear_pc;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned order [15];

    reorder_buffer #(.ROB_SIZE_LOG(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_is_branch (issue_is_branch),
        .issue_pred_jump (issue_pred_jump),
        .issue_alt_pc    (issue_alt_pc),
        .issue_tag       (issue_tag),
        .rob_full        (rob_full),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_val         (cdb_val),
        .cdb_jump        (cdb_jump),
        .query_tag_1     (query_tag_1),
        .query_ready_1   (query_ready_1),
        .query_val_1     (query_val_1),
        .query_tag_2     (query_tag_2),
        .query_ready_2   (query_ready_2),
        .query_val_2     (query_val_2),
        .commit_reg      (commit_reg),
        .commit_val      (commit_val),
        .commit_tag      (commit_tag),
        .RoB_clear       (RoB_clear),
        .clear_pc        (clear_pc)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rd, input logic br,
                             input logic pred, input logic [31:0] alt);
        issue_valid     = v;
        issue_rd        = rd;
        issue_is_branch = br;
        issue_pred_jump = pred;
        issue_alt_pc    = alt;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] tag, input logic [31:0] val,
                           input logic jump);
        cdb_valid = v;
        cdb_tag   = tag;
        cdb_val   = val;
        cdb_jump  = jump;
    endtask

    task automatic async_reset();
        #1 rst_in = 1'b1;
        #2 rst_in = 1'b0;
        #1;
    endtask

    function automatic logic [4:0] wrap_rd(input int unsigned tag);
        return (tag >= 4) ? 5'(tag + 1) : 5'(20 + tag);
    endfunction

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        set_issue(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        set_cdb(1'b0, 4'd0, 32'h0, 1'b0);
        query_tag_1 = 4'd0;
        query_tag_2 = 4'd0;
        #1;
        check("rst_commit_reg", 32'(commit_reg), 32'd0);
        check("rst_rob_clear", 32'(RoB_clear), 32'd0);
        check("rst_clear_pc", clear_pc, 32'd0);
        check("rst_rob_full", 32'(rob_full), 32'd0);
        check("rst_issue_tag", 32'(issue_tag), 32'd0);
        tick();
        rst_in = 1'b0;
        tick();

        // Basic issue -> CDB -> commit
        set_issue(1'b1, 5'd5, 1'b0, 1'b0, 32'h0);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        check("t1_issue_tag", 32'(issue_tag), 32'd1);
        set_cdb(1'b1, 4'd0, 32'h1234, 1'b0);
        #1;
        check("t1_query_not_ready", 32'(query_ready_1), 32'd0);
        tick();
        set_cdb(1'b0, 4'd0, 32'h0, 1'b0);
        #1;
        check("t1_query_ready", 32'(query_ready_1), 32'd1);
        check("t1_query_val", query_val_1, 32'h1234);
        check("t1_no_commit_yet", 32'(commit_reg), 32'd0);
        tick();
        check("t1_commit_reg", 32'(commit_reg), 32'd5);
        check("t1_commit_val", commit_val, 32'h1234);
        check("t1_commit_tag", 32'(commit_tag), 32'd0);
        rdy_in = 1'b0;
        tick();
        check("t1_stall_holds", 32'(commit_reg), 32'd5);
        rdy_in = 1'b1;
        tick();
        check("t1_pulse_end", 32'(commit_reg), 32'd0);

        // Fill to 16, reject 17th, out-of-order completion
        async_reset();
        check("t2_reset_tag", 32'(issue_tag), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_fill_tag%0d", i), 32'(issue_tag), 32'(i));
            set_issue(1'b1, 5'(i + 1), 1'b0, 1'b0, 32'h0);
            tick();
        end
        check("t2_full", 32'(rob_full), 32'd1);
        set_issue(1'b1, 5'd31, 1'b0, 1'b0, 32'h0);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        check("t2_17th_full", 32'(rob_full), 32'd1);
        check("t2_17th_tag", 32'(issue_tag), 32'd0);
        set_cdb(1'b1, 4'd3, 32'h33, 1'b0);
        tick();
        check("t2_no_commit_tag3_first", 32'(commit_reg), 32'd0);
        set_cdb(1'b1, 4'd0, 32'h10, 1'b0);
        tick();
        set_cdb(1'b1, 4'd1, 32'h11, 1'b0);
        tick();
        check("t2_c0_reg", 32'(commit_reg), 32'd1);
        check("t2_c0_val", commit_val, 32'h10);
        check("t2_c0_tag", 32'(commit_tag), 32'd0);
        check("t2_not_full", 32'(rob_full), 32'd0);
        set_cdb(1'b1, 4'd2, 32'h22, 1'b0);
        tick();
        check("t2_c1_tag", 32'(commit_tag), 32'd1);
        check("t2_c1_val", commit_val, 32'h11);
        set_cdb(1'b0, 4'd0, 32'h0, 1'b0);
        tick();
        check("t2_c2_tag", 32'(commit_tag), 32'd2);
        tick();
        check("t2_c3_tag", 32'(commit_tag), 32'd3);
        check("t2_c3_reg", 32'(commit_reg), 32'd4);
        check("t2_c3_val", commit_val, 32'h33);
        tick();
        check("t2_idle", 32'(commit_reg), 32'd0);

        // Wrap-around reuse of tags 0..3
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_wrap_tag%0d", i), 32'(issue_tag), 32'(i));
            set_issue(1'b1, 5'(20 + i), 1'b0, 1'b0, 32'h0);
            tick();
        end
        set_issue(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        check("t3_full", 32'(rob_full), 32'd1);

        // Issue while full in the same cycle as a commit is rejected
        set_cdb(1'b1, 4'd4, 32'h44, 1'b0);
        tick();
        set_cdb(1'b0, 4'd0, 32'h0, 1'b0);
        set_issue(1'b1, 5'd30, 1'b0, 1'b0, 32'h0);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        check("t5_commit_tag", 32'(commit_tag), 32'd4);
        check("t5_commit_reg", 32'(commit_reg), 32'd5);
        check("t5_not_full", 32'(rob_full), 32'd0);
        check("t5_issue_rejected", 32'(issue_tag), 32'd4);

        // Drain remaining entries across the wrap in program order
        for (int j = 0; j < 11; j++) order[j] = 32'(5 + j);
        for (int j = 0; j < 4; j++) order[11 + j] = 32'(j);
        for (int j = 0; j < 15; j++) begin
            set_cdb(1'b1, 4'(order[j]), 32'h500 + order[j], 1'b0);
            tick();
            if (j > 0) begin
                check($sformatf("t3_order_tag%0d", j), 32'(commit_tag), order[j - 1]);
                check($sformatf("t3_order_reg%0d", j), 32'(commit_reg), 32'(wrap_rd(order[j - 1])));
                check($sformatf("t3_order_val%0d", j), commit_val, 32'h500 + order[j - 1]);
            end
        end
        set_cdb(1'b0, 4'd0, 32'h0, 1'b0);
        tick();
        check("t3_last_tag", 32'(commit_tag), 32'd3);
        check("t3_last_reg", 32'(commit_reg), 32'd23);
        check("t3_empty_tag", 32'(issue_tag), 32'd4);

        // Mispredicted branch: pred 0, actual 1
        set_issue(1'b1, 5'd0, 1'b1, 1'b0, 32'h100);
        tick();
        set_issue(1'b1, 5'd9, 1'b0, 1'b0, 32'h0);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        set_cdb(1'b1, 4'd4, 32'h0, 1'b1);
        tick();
        set_cdb(1'b0, 4'd0, 32'h0, 1'b0);
        check("t4_no_clear_yet", 32'(RoB_clear), 32'd0);
        tick();
        check("t4_branch_commit_tag", 32'(commit_tag), 32'd4);
        check("t4_rob_clear", 32'(RoB_clear), 32'd1);
        check("t4_clear_pc", clear_pc, 32'h100);
        check("t4_tag_reset", 32'(issue_tag), 32'd0);
        check("t4_not_full", 32'(rob_full), 32'd0);
        set_issue(1'b1, 5'd7, 1'b0, 1'b0, 32'h0);
        set_cdb(1'b1, 4'd5, 32'h77, 1'b0);
        query_tag_2 = 4'd5;
        tick();
        set_cdb(1'b0, 4'd0, 32'h0, 1'b0);
        check("t4_clear_pulse_end", 32'(RoB_clear), 32'd0);
        check("t4_clear_commit_reg", 32'(commit_reg), 32'd0);
        check("t4_issue_dropped", 32'(issue_tag), 32'd0);
        check("t4_cdb_dropped", 32'(query_ready_2), 32'd0);
        set_issue(1'b1, 5'd8, 1'b0, 1'b0, 32'h0);
        tick();
        check("t4_issue_after_clear", 32'(issue_tag), 32'd1);

        // Async reset while RoB_clear is high
        set_issue(1'b1, 5'd0, 1'b1, 1'b1, 32'h200);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        set_cdb(1'b1, 4'd0, 32'h1, 1'b0);
        tick();
        set_cdb(1'b1, 4'd1, 32'h0, 1'b0);
        tick();
        check("t6_commit_reg", 32'(commit_reg), 32'd8);
        set_cdb(1'b0, 4'd0, 32'h0, 1'b0);
        tick();
        check("t6_rob_clear", 32'(RoB_clear), 32'd1);
        check("t6_clear_pc", clear_pc, 32'h200);
        #2 rst_in = 1'b1;
        #1;
        check("t6_rst_rob_clear", 32'(RoB_clear), 32'd0);
        check("t6_rst_clear_pc", clear_pc, 32'd0);
        check("t6_rst_commit_tag", 32'(commit_tag), 32'd0);
        check("t6_rst_commit_reg", 32'(commit_reg), 32'd0);
        rst_in = 1'b0;
        tick();
        check("t6_no_pulse_1", 32'(RoB_clear), 32'd0);
        tick();
        check("t6_no_pulse_2", 32'(RoB_clear), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the Tomasulo core. The issue stage allocates one entry per instruction and receives its tag. Execution units broadcast results on the CDB. Entries retire strictly in program order. Retirement drives the register file's commit write and tag-release inputs, and branch mispredicts drive the global `RoB_clear` flush.

## Interface
Parameters:
- `ROB_SIZE_LOG`, default 4: entry count is 2^ROB_SIZE_LOG, which gives 16 entries and 4-bit tags.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: when low, all state and outputs freeze.
- `issue_valid` in 1: allocate one entry this cycle.
- `issue_rd` in 5: destination register; 0 means no write.
- `issue_is_branch` in 1: entry is a conditional branch.
- `issue_pred_jump` in 1: predicted taken.
- `issue_alt_pc` in 32: redirect PC used if the prediction is wrong.
- `issue_tag` out 4: tag the next allocation receives (current tail), combinational.
- `rob_full` out 1: count == 16, combinational.
- `cdb_valid` in 1, `cdb_tag` in 4, `cdb_val` in 32, `cdb_jump` in 1: result broadcast; `cdb_jump` is the actual branch outcome.
- `query_tag_1` in 4, `query_ready_1` out 1, `query_val_1` out 32: operand lookup for a pending tag, combinational.
- `query_tag_2` in 4, `query_ready_2` out 1, `query_val_2` out 32: second operand lookup, same rules.
- `commit_reg` out 5, `commit_val` out 32, `commit_tag` out 4: registered one-cycle retirement write; `commit_reg` = 0 when idle.
- `RoB_clear` out 1: registered one-cycle flush pulse.
- `clear_pc` out 32: fetch redirect target, valid while `RoB_clear` is high.

## Operation
- Circular buffer with `head`, `tail` and a 5-bit `count`. Pointers wrap modulo 16.
- Each entry holds: busy, ready, rd, val, is_branch, pred_jump, jump, alt_pc.
- Issue: when `issue_valid` is high and not full, the entry at tail is written busy=1, ready=0; tail advances and count increments. Issuing while full is an upstream error; the RoB ignores it.
- CDB: when `cdb_valid` is high and the entry at `cdb_tag` is busy, write ready=1, val=`cdb_val`, jump=`cdb_jump`.
- Commit: when the head entry is busy and ready, it retires. The RoB registers `commit_reg`=rd, `commit_val`=val and `commit_tag`=head; head advances and count decrements. At most one commit per cycle.
- Mispredict: the commit itself proceeds normally, so rd is still written. When the head entry has is_branch=1 and jump != pred_jump:
  - The flush is scheduled for the next cycle.
  - In that next cycle, `RoB_clear`=1 and `clear_pc`=alt_pc. All busy bits clear and head, tail and count return to 0.
  - Issue and CDB inputs in the clear cycle are ignored. `commit_reg`=0 in the clear cycle.
- Query: `query_ready_x` = busy & ready of the entry at `query_tag_x`; `query_val_x` is that entry's val.
- Simultaneous issue and commit: count is unchanged. Full is evaluated from start-of-cycle state, so a commit does not free a slot for an issue in the same cycle.
- Reset: all entries not busy, pointers 0, count 0. Output reset values: all commit outputs 0, `RoB_clear`=0, `clear_pc`=0, `rob_full`=0, `issue_tag`=0. Reset mid-flush drops the pending clear.

## Timing
- Issue → visible in entry: next edge.
- CDB write → head may commit: the following cycle (one-cycle gap) without bypass.
- Commit outputs change on the edge where head advances and persist for exactly one cycle.
- Mispredicting commit in cycle N → `RoB_clear` high in cycle N+1 only → first legal issue in cycle N+2.
- With `rdy_in` low: no pointer, entry or output changes, including pulses. Pulses resume when `rdy_in` returns high.

## Configuration
- `ROB_CDB_BYPASS_EN` defined:
  - The head commits in the same cycle its CDB broadcast arrives, taking val and jump directly from the CDB. Latency from CDB to commit is one edge.
  - Query outputs also forward a matching CDB broadcast combinationally.
- Undefined: the one-cycle gap described under Timing; queries see only stored entries.

## Structure
- Shared package `rob_pkg`: `ROB_SIZE_LOG`, `ROB_SIZE`, the `rob_tag_t` typedef and the `rob_entry_t` struct.
- One sub-module, `rob_entry_array`: entry storage with one issue write port, one CDB write port and three combinational read ports (head, query_1, query_2).

## Test plan
- Issue rd=5, then CDB tag0 val=0x1234 → `commit_reg`=5, `commit_val`=0x1234, `commit_tag`=0, one-cycle pulse.
- Issue 16 entries → `rob_full`=1. A 17th issue is ignored. Completing the results out of order (tag 3 before tag 0) still commits in order 0, 1, 2, 3.
- Wrap-around: fill to 16, commit 4, issue 4 → `issue_tag` sequence 0..3 reused; commit order preserved.
- Branch with pred_jump=0, actual jump=1, alt_pc=0x100 → branch commits, next cycle `RoB_clear`=1 and `clear_pc`=0x100; count 0; an issue during the clear cycle is dropped.
- Same-cycle issue and commit while count=16 → issue is rejected and count goes to 15.
- Assert `rst_in` asynchronously mid-flush → all outputs 0 immediately, no `RoB_clear` pulse afterward.
